// File: rtl/button_conditioner_if.sv
// Button pins in, conditioned per-channel events out.
// slave is the conditioner side; master is the pin driver / event consumer.
interface button_conditioner_if #(
  parameter int N_BTN = 4
);
  logic [N_BTN-1:0] button;
  logic [N_BTN-1:0] held;
  logic [N_BTN-1:0] press;
  logic [N_BTN-1:0] rel;
  logic [N_BTN-1:0] long;
  logic [N_BTN-1:0] rpt;

  modport master (
    output button,
    input  held,
    input  press,
    input  rel,
    input  long,
    input  rpt
  );

  modport slave (
    input  button,
    output held,
    output press,
    output rel,
    output long,
    output rpt
  );
endinterface

// File: rtl/button_conditioner.sv
// Multi-channel push-button conditioner: sync, debounce, press/release pulses, long-press.
// Define BTN_AUTOREPEAT_EN to compile in the per-channel auto-repeat pulse generator.
module button_conditioner #(
  parameter int N_BTN        = 4,
  parameter int ACTIVE_LOW   = 1,
  parameter int DEBOUNCE_CYC = 4,
  parameter int LONG_CYC     = 128,
  parameter int REPEAT_CYC   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  button_conditioner_if.slave  bus,
  output logic [2*N_BTN-1:0]   o_dbg_state
);

  localparam int DW = $clog2(DEBOUNCE_CYC + 1);
  localparam int HW = $clog2(LONG_CYC + 1);
  localparam logic [DW-1:0] D_LAST    = DW'(DEBOUNCE_CYC - 1);
  localparam logic [HW-1:0] HCNT_LAST = HW'(LONG_CYC - 1);
  localparam logic [HW-1:0] HCNT_MAX  = HW'(LONG_CYC);
  localparam logic          IDLE_PIN  = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_LONG    = 2'd2
  } state_t;

  for (genvar g = 0; g < N_BTN; g++) begin : g_ch
    logic          r_sync1, r_sync2;
    logic          r_held, r_press, r_rel, r_long;
    logic [DW-1:0] r_dcnt;
    logic [HW-1:0] r_hcnt;
    state_t        r_state;
    logic          w_s, w_settle, w_press, w_release, w_long_rise;

    assign w_s         = (ACTIVE_LOW != 0) ? ~r_sync2 : r_sync2;
    // The sample that completes DEBOUNCE_CYC consecutive disagreements commits the new level.
    assign w_settle    = (w_s != r_held) && (r_dcnt == D_LAST);
    assign w_press     = w_settle & ~r_held;
    assign w_release   = w_settle & r_held;
    assign w_long_rise = (r_state == ST_PRESSED) && !w_release && (r_hcnt == HCNT_LAST);

    always_ff @(posedge clk) begin
      if (rst) begin
        r_sync1 <= IDLE_PIN;
        r_sync2 <= IDLE_PIN;
        r_held  <= 1'b0;
        r_press <= 1'b0;
        r_rel   <= 1'b0;
        r_long  <= 1'b0;
        r_dcnt  <= '0;
        r_hcnt  <= '0;
        r_state <= ST_IDLE;
      end else begin
        r_sync1 <= bus.button[g];
        r_sync2 <= r_sync1;
        r_press <= w_press;
        r_rel   <= w_release;
        if (w_settle || (w_s == r_held)) r_dcnt <= '0;
        else                             r_dcnt <= r_dcnt + 1'b1;
        if (w_settle) r_held <= w_s;

        case (r_state)
          ST_IDLE: begin
            r_hcnt <= '0;
            r_long <= 1'b0;
            if (w_press) r_state <= ST_PRESSED;
          end
          ST_PRESSED: begin
            if (w_release) begin
              r_hcnt  <= '0;
              r_state <= ST_IDLE;
            end else begin
              r_hcnt <= r_hcnt + 1'b1;
              if (w_long_rise) begin
                r_long  <= 1'b1;
                r_state <= ST_LONG;
              end
            end
          end
          ST_LONG: begin
            // long drops on the same edge that launches the rel pulse.
            if (w_release) begin
              r_hcnt  <= '0;
              r_long  <= 1'b0;
              r_state <= ST_IDLE;
            end else if (r_hcnt != HCNT_MAX) begin
              r_hcnt <= r_hcnt + 1'b1;
            end
          end
          default: begin
            r_hcnt  <= '0;
            r_long  <= 1'b0;
            r_state <= ST_IDLE;
          end
        endcase
      end
    end

    assign bus.held[g]  = r_held;
    assign bus.press[g] = r_press;
    assign bus.rel[g]   = r_rel;
    assign bus.long[g]  = r_long;
    assign o_dbg_state[2*g +: 2] = r_state;

`ifdef BTN_AUTOREPEAT_EN
    localparam int RW = (REPEAT_CYC > 1) ? $clog2(REPEAT_CYC) : 1;
    localparam logic [RW-1:0] R_LAST = RW'(REPEAT_CYC - 1);
    logic [RW-1:0] r_rcnt;
    logic          r_rpt;

    // First pulse coincides with long rising, then one every REPEAT_CYC cycles.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_rcnt <= '0;
        r_rpt  <= 1'b0;
      end else if (w_long_rise) begin
        r_rcnt <= '0;
        r_rpt  <= 1'b1;
      end else if ((r_state == ST_LONG) && !w_release) begin
        if (r_rcnt == R_LAST) begin
          r_rcnt <= '0;
          r_rpt  <= 1'b1;
        end else begin
          r_rcnt <= r_rcnt + 1'b1;
          r_rpt  <= 1'b0;
        end
      end else begin
        r_rcnt <= '0;
        r_rpt  <= 1'b0;
      end
    end

    assign bus.rpt[g] = r_rpt;
`else
    assign bus.rpt[g] = 1'b0;
`endif
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner: N_BTN=2, active-low, DEBOUNCE_CYC=4, LONG_CYC=16, REPEAT_CYC=4.
// rpt expectations follow BTN_AUTOREPEAT_EN.
module tb_button_conditioner;
  localparam int N_BTN = 2;

`ifdef BTN_AUTOREPEAT_EN
  localparam bit AR_EN = 1'b1;
`else
  localparam bit AR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2*N_BTN-1:0] dbg_state;
  int tests_run    = 0;
  int tests_failed = 0;

  button_conditioner_if #(.N_BTN(N_BTN)) bus ();

  button_conditioner #(
    .N_BTN(N_BTN), .ACTIVE_LOW(1), .DEBOUNCE_CYC(4), .LONG_CYC(16), .REPEAT_CYC(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .o_dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [9:0] all_outs();
    return {bus.held, bus.press, bus.rel, bus.long, bus.rpt};
  endfunction

  logic       exp_long, exp_rpt;

  initial begin
    // reset with both pins idle (high)
    bus.button = 2'b11;
    rst = 1'b1;
    repeat (3) step();
    check_eq("reset outs", all_outs(), 10'd0);
    check_eq("reset state", dbg_state, 4'd0);
    rst = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      step();
      check_eq($sformatf("post-reset idle i=%0d", i), all_outs(), 10'd0);
    end

    // clean press on channel 0
    bus.button = 2'b10;
    for (int i = 1; i <= 8; i++) begin
      step();
      check_eq($sformatf("clean press i=%0d", i), bus.press, (i == 6) ? 2'b01 : 2'b00);
      check_eq($sformatf("clean held i=%0d", i), bus.held, (i >= 6) ? 2'b01 : 2'b00);
    end
    check_eq("pressed state", dbg_state, 4'b0001);
    bus.button = 2'b11;
    for (int i = 1; i <= 8; i++) begin
      step();
      check_eq($sformatf("clean rel i=%0d", i), bus.rel, (i == 6) ? 2'b01 : 2'b00);
      check_eq($sformatf("clean rel held i=%0d", i), bus.held, (i < 6) ? 2'b01 : 2'b00);
      check_eq($sformatf("clean rel long i=%0d", i), bus.long, 2'b00);
    end

    // glitch of 3 cycles must be rejected
    bus.button = 2'b10;
    for (int i = 1; i <= 13; i++) begin
      step();
      if (i == 3) bus.button = 2'b11;
      check_eq($sformatf("glitch i=%0d", i), {bus.held, bus.press, bus.rel}, 6'd0);
    end

    // bouncy press: low 2, high 1, then steady low
    bus.button = 2'b10;
    step();
    check_eq("bounce a", bus.press, 2'b00);
    step();
    check_eq("bounce b", bus.press, 2'b00);
    bus.button = 2'b11;
    step();
    check_eq("bounce c", bus.press, 2'b00);
    bus.button = 2'b10;
    for (int i = 1; i <= 10; i++) begin
      step();
      check_eq($sformatf("bounce press i=%0d", i), bus.press, (i == 6) ? 2'b01 : 2'b00);
    end
    bus.button = 2'b11;
    for (int i = 1; i <= 8; i++) begin
      step();
      check_eq($sformatf("bounce rel i=%0d", i), bus.rel, (i == 6) ? 2'b01 : 2'b00);
    end

    // long press on channel 1, release after 42 cycles so rel lands on a would-be rpt slot
    bus.button = 2'b01;
    for (int i = 1; i <= 6; i++) begin
      step();
      check_eq($sformatf("lp press i=%0d", i), bus.press, (i == 6) ? 2'b10 : 2'b00);
    end
    for (int n = 1; n <= 52; n++) begin
      step();
      exp_long = (n >= 16) && (n < 48);
      exp_rpt  = AR_EN && exp_long && (((n - 16) % 4) == 0);
      check_eq($sformatf("lp long n=%0d", n), bus.long, {exp_long, 1'b0});
      check_eq($sformatf("lp rpt n=%0d", n), bus.rpt, {exp_rpt, 1'b0});
      check_eq($sformatf("lp rel n=%0d", n), bus.rel, (n == 48) ? 2'b10 : 2'b00);
      check_eq($sformatf("lp held n=%0d", n), bus.held, (n < 48) ? 2'b10 : 2'b00);
      check_eq($sformatf("lp press n=%0d", n), bus.press, 2'b00);
      if (n == 42) bus.button = 2'b11;
    end

    // simultaneous press on both channels, then reset while long-held
    bus.button = 2'b00;
    for (int i = 1; i <= 6; i++) begin
      step();
      check_eq($sformatf("sim press i=%0d", i), bus.press, (i == 6) ? 2'b11 : 2'b00);
    end
    for (int n = 1; n <= 18; n++) begin
      step();
      check_eq($sformatf("sim long n=%0d", n), bus.long, (n >= 16) ? 2'b11 : 2'b00);
    end
    check_eq("sim long state", dbg_state, 4'b1010);
    rst = 1'b1;
    step();
    check_eq("mid rst outs", all_outs(), 10'd0);
    check_eq("mid rst state", dbg_state, 4'd0);
    step();
    check_eq("mid rst outs 2", all_outs(), 10'd0);
    rst = 1'b0;
    // buttons still held through reset: expect a fresh press
    for (int i = 1; i <= 8; i++) begin
      step();
      check_eq($sformatf("post rst press i=%0d", i), bus.press, (i == 6) ? 2'b11 : 2'b00);
      check_eq($sformatf("post rst rel i=%0d", i), bus.rel, 2'b00);
    end

    bus.button = 2'b11;
    repeat (10) step();
    check_eq("final idle held", bus.held, 2'b00);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
